// File: rtl/seg7_scan_if.sv
// Bus between the digit source and the 7-segment scan controller.
// The source side (master) supplies BCD digits; the controller (slave) drives the display pins.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_done;

  modport master (
    output value_in, load, dp_in,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  value_in, load, dp_in,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a per-slot guard gap.
// Optional macro SEG7_LZ_BLANK_EN enables leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  seg7_scan_if.slave bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      default: seg_decode = 7'b0001100;
    endcase
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_q, pend_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;
  logic [0:0]            state;
  logic [3:0]            cur_digit;
  logic                  blank;

  assign state     = (cnt_q < GUARD_END) ? ST_GUARD : ST_DRIVE;
  assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0] hi_nz;

  // Digit 0 is never blanked, so the search starts at digit 1 with a default of 0.
  always_comb begin
    hi_nz = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (shadow_q[4*k +: 4] != 4'd0) hi_nz = IDX_W'(k);
    end
  end

  assign blank = (idx_q > hi_nz);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    fd_d  = 1'b0;
    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      fd_d  = (idx_q == LAST_IDX);
    end
  end

  // The boundary is the cycle frame_done is high; shadow only changes there.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    if (fd_q) begin
      pend_d = 1'b0;
      if (bus.load) begin
        shadow_d    = bus.value_in;
        shadow_dp_d = bus.dp_in;
      end else if (pend_q) begin
        shadow_d    = pend_val_q;
        shadow_dp_d = pend_dp_q;
      end
    end else if (bus.load) begin
      pend_val_d = bus.value_in;
      pend_dp_d  = bus.dp_in;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state == ST_DRIVE && !blank) begin
      an_d[idx_q] = 1'b0;
      seg_d       = seg_decode(cur_digit);
      dp_d        = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_q      <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
      fd_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_q      <= pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      fd_q        <= fd_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule
